// File: rtl/hv_owt_tx_sched.sv
// hv_owt_tx_sched
// Shares the single one-wire TX frame engine among REQ_NUM requesters.
// A winner is latched in IDLE, the engine gets a one-cycle wr/rd command
// pulse while addr/data stay frozen for the whole frame, completion is
// taken from the engine busy flag, a frame that never starts is timed
// out, and an idle gap is forced before the next grant.
//
// Build option: define HV_OWT_TX_SCHED_RR_EN for round-robin arbitration
// (search starts one past the last granted index). Left undefined, the
// lowest requester index always wins and no pointer register exists.

module hv_owt_tx_sched #(
  parameter int REQ_NUM      = 3,
  parameter int REG_AW       = 7,
  parameter int DATA_W       = 10,
  parameter int GAP_CYC      = 24,
  parameter int START_TO_CYC = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [REQ_NUM-1:0]         i_req,
  input  logic [REQ_NUM-1:0]         i_req_wr,
  input  logic [REQ_NUM*REG_AW-1:0]  i_req_addr,
  input  logic [REQ_NUM*DATA_W-1:0]  i_req_data,
  output logic [REQ_NUM-1:0]         o_ack,
  output logic [REQ_NUM-1:0]         o_done,
  output logic                       o_tx_err,
  input  logic                       i_tx_en,
  input  logic                       i_owt_tx_busy,
  output logic                       o_owt_tx_wr_cmd_vld,
  output logic                       o_owt_tx_rd_cmd_vld,
  output logic [REG_AW-1:0]          o_owt_tx_addr,
  output logic [DATA_W-1:0]          o_owt_tx_data
);

  localparam int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_MAX = (GAP_CYC > START_TO_CYC) ? GAP_CYC : START_TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]   START_LAST = CNT_W'(START_TO_CYC - 1);
  localparam logic [REQ_NUM-1:0] ONE_OH     = REQ_NUM'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [REQ_NUM-1:0]  r_grant;
  logic [REQ_NUM-1:0]  r_ack;
  logic [REQ_NUM-1:0]  r_done;
  logic                r_err;
  logic                r_wr_cmd;
  logic                r_rd_cmd;
  logic [REG_AW-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;

  logic [REQ_NUM-1:0]  w_ack_nxt;
  logic [REQ_NUM-1:0]  w_done_nxt;
  logic                w_err_nxt;
  logic                w_wr_cmd_nxt;
  logic                w_rd_cmd_nxt;
  logic                w_load;

  logic                w_win_vld;
  logic [IDX_W-1:0]    w_win_idx;
  logic [REQ_NUM-1:0]  w_win_oh;
  logic                w_win_wr;
  logic [REG_AW-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;

`ifdef HV_OWT_TX_SCHED_RR_EN
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [IDX_W:0]      w_rr_pos;

  // Round-robin winner: walk from the lowest-priority slot (the last grant)
  // towards the highest (last grant + 1) so the final hit is the winner.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_rr_pos  = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      w_rr_pos  = {1'b0, r_ptr} + (IDX_W + 1)'(k + 1);
      w_rr_pos  = (w_rr_pos >= (IDX_W + 1)'(REQ_NUM)) ?
                  (w_rr_pos - (IDX_W + 1)'(REQ_NUM)) : w_rr_pos;
      w_win_idx = i_req[w_rr_pos[IDX_W-1:0]] ? w_rr_pos[IDX_W-1:0] : w_win_idx;
      w_win_vld = w_win_vld | i_req[w_rr_pos[IDX_W-1:0]];
    end
  end

  // Round-robin pointer advances to the granted index in the ISSUE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= IDX_W'(REQ_NUM - 1);
      r_grant_idx <= '0;
    end else begin
      if (w_load) begin
        r_grant_idx <= w_win_idx;
      end
      if (r_state == ST_ISSUE) begin
        r_ptr <= r_grant_idx;
      end
    end
  end
`else
  // Fixed priority winner: scan from the top so the lowest set index wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      w_win_idx = i_req[k] ? IDX_W'(k) : w_win_idx;
      w_win_vld = w_win_vld | i_req[k];
    end
  end
`endif

  // Payload mux for the selected requester and its one-hot grant vector.
  always_comb begin
    w_win_oh   = ONE_OH << w_win_idx;
    w_win_wr   = 1'b0;
    w_win_addr = '0;
    w_win_data = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      w_win_wr   = (w_win_idx == IDX_W'(k)) ? i_req_wr[k] : w_win_wr;
      w_win_addr = (w_win_idx == IDX_W'(k)) ? i_req_addr[k*REG_AW +: REG_AW] : w_win_addr;
      w_win_data = (w_win_idx == IDX_W'(k)) ? i_req_data[k*DATA_W +: DATA_W] : w_win_data;
    end
  end

  // Next state, counter and next values of every registered pulse output.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_ack_nxt    = '0;
    w_done_nxt   = '0;
    w_err_nxt    = 1'b0;
    w_wr_cmd_nxt = 1'b0;
    w_rd_cmd_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_tx_en && w_win_vld) begin
          w_load       = 1'b1;
          w_ack_nxt    = w_win_oh;
          w_wr_cmd_nxt = w_win_wr;
          w_rd_cmd_nxt = ~w_win_wr;
          w_state_nxt  = ST_ISSUE;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (i_owt_tx_busy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt == START_LAST) begin
          // Engine never picked the command up: abort the frame.
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_done_nxt  = r_grant;
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!i_owt_tx_busy) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = r_grant;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and shared cycle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pulse outputs plus grant and payload latched on the winning IDLE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_wr_cmd <= 1'b0;
      r_rd_cmd <= 1'b0;
      r_grant  <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_ack    <= w_ack_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_wr_cmd <= w_wr_cmd_nxt;
      r_rd_cmd <= w_rd_cmd_nxt;
      if (w_load) begin
        r_grant <= w_win_oh;
        r_addr  <= w_win_addr;
        r_data  <= w_win_data;
      end
    end
  end

  assign o_ack               = r_ack;
  assign o_done              = r_done;
  assign o_tx_err            = r_err;
  assign o_owt_tx_wr_cmd_vld = r_wr_cmd;
  assign o_owt_tx_rd_cmd_vld = r_rd_cmd;
  assign o_owt_tx_addr       = r_addr;
  assign o_owt_tx_data       = r_data;

endmodule

// File: tb/tb_hv_owt_tx_sched.sv
// tb_hv_owt_tx_sched
// Directed scenarios followed by random traffic. The reference is a
// timeline model: each accepted request becomes a frame record holding the
// cycle numbers of its ack/command and of its done pulse, derived from the
// engine behaviour the bench itself plays back. Build with
// HV_OWT_TX_SCHED_RR_EN defined to check the round-robin variant.

module tb_hv_owt_tx_sched;

  localparam int N   = 3;
  localparam int IW  = 2;
  localparam int AW  = 7;
  localparam int DW  = 10;
  localparam int GAP = 24;
  localparam int STO = 8;
  localparam logic [N-1:0] ONE_OH = N'(1);

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    i_req;
  logic [N-1:0]    i_req_wr;
  logic [N*AW-1:0] i_req_addr;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_ack;
  logic [N-1:0]    o_done;
  logic            o_tx_err;
  logic            i_tx_en;
  logic            i_owt_tx_busy;
  logic            o_owt_tx_wr_cmd_vld;
  logic            o_owt_tx_rd_cmd_vld;
  logic [AW-1:0]   o_owt_tx_addr;
  logic [DW-1:0]   o_owt_tx_data;

  hv_owt_tx_sched #(
    .REQ_NUM(N), .REG_AW(AW), .DATA_W(DW), .GAP_CYC(GAP), .START_TO_CYC(STO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req(i_req), .i_req_wr(i_req_wr), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_ack(o_ack), .o_done(o_done), .o_tx_err(o_tx_err),
    .i_tx_en(i_tx_en), .i_owt_tx_busy(i_owt_tx_busy),
    .o_owt_tx_wr_cmd_vld(o_owt_tx_wr_cmd_vld), .o_owt_tx_rd_cmd_vld(o_owt_tx_rd_cmd_vld),
    .o_owt_tx_addr(o_owt_tx_addr), .o_owt_tx_data(o_owt_tx_data)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  // current frame record
  int fI, fD, fg;
  bit fwr, fto;
  logic [AW-1:0] faddr, exp_addr;
  logic [DW-1:0] fdata, exp_data;
  // scheduler availability and engine playback
  int next_idle, bs, be, rr_last;
  bit in_rst;
  int eng_d, eng_L;
  bit eng_to, eng_rand;
  // direct observations
  bit meas_gap;
  int last_done_obs;
  logic [N-1:0] ack_log[$];
  // random requesters
  bit rq_on[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] ea, ed;
    if (cyc == fI) begin
      exp_addr = faddr;
      exp_data = fdata;
    end
    ea = (cyc == fI) ? (ONE_OH << fg) : '0;
    ed = (cyc == fD) ? (ONE_OH << fg) : '0;
    chk("ack",    32'(o_ack), 32'(ea));
    chk("wr_cmd", 32'(o_owt_tx_wr_cmd_vld), 32'((cyc == fI) && fwr));
    chk("rd_cmd", 32'(o_owt_tx_rd_cmd_vld), 32'((cyc == fI) && !fwr));
    chk("done",   32'(o_done), 32'(ed));
    chk("tx_err", 32'(o_tx_err), 32'((cyc == fD) && fto));
    chk("addr",   32'(o_owt_tx_addr), 32'(exp_addr));
    chk("data",   32'(o_owt_tx_data), 32'(exp_data));
    if (meas_gap && (o_owt_tx_wr_cmd_vld || o_owt_tx_rd_cmd_vld) && last_done_obs >= 0)
      chk("gap_spacing", 32'(cyc - last_done_obs), 32'(GAP + 1));
    if (o_done != '0) last_done_obs = cyc;
    if (o_ack != '0) ack_log.push_back(o_ack);
  endtask

  // Decide what the scheduler accepts at the edge closing the current cycle.
  task automatic plan();
    int w, j;
    if (!in_rst && cyc >= next_idle && i_tx_en && (i_req != '0)) begin
      w = -1;
`ifdef HV_OWT_TX_SCHED_RR_EN
      for (int k = 1; k <= N; k++) begin
        j = (rr_last + k) % N;
        if (w < 0 && i_req[j[IW-1:0]]) w = j;
      end
      rr_last = w;
`else
      for (int k = N - 1; k >= 0; k--) begin
        j = k;
        if (i_req[j[IW-1:0]]) w = k;
      end
`endif
      fg    = w;
      fI    = cyc + 1;
      fwr   = i_req_wr[w[IW-1:0]];
      faddr = i_req_addr[w*AW +: AW];
      fdata = i_req_data[w*DW +: DW];
      if (eng_rand) begin
        eng_to = ($urandom_range(0, 4) == 0);
        eng_d  = $urandom_range(1, STO);
        eng_L  = $urandom_range(1, 40);
      end
      if (eng_to) begin
        bs = 0; be = 0; fto = 1'b1;
        fD = fI + STO + 1;
      end else begin
        bs = fI + eng_d; be = bs + eng_L; fto = 1'b0;
        fD = be + 1;
      end
      next_idle = fD + GAP;
    end
  endtask

  task automatic cycle_end();
    plan();
    @(posedge i_clk);
    #1;
    cyc++;
    i_owt_tx_busy = (cyc >= bs) && (cyc < be);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_end();
  endtask

  task automatic model_reset();
    fI = -1; fD = -1; fg = 0; fwr = 1'b0; fto = 1'b0;
    exp_addr = '0; exp_data = '0;
    bs = 0; be = 0; rr_last = N - 1; in_rst = 1'b1;
    i_owt_tx_busy = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    i_rst_n = 1'b0; i_req = '0; i_req_wr = '0; i_req_addr = '0; i_req_data = '0;
    i_tx_en = 1'b0; i_owt_tx_busy = 1'b0;
    cyc = 0; next_idle = 0; meas_gap = 1'b0; last_done_obs = -1; eng_rand = 1'b0;
    eng_d = 2; eng_L = 5; eng_to = 1'b0;
    for (int k = 0; k < N; k++) rq_on[k] = 1'b0;
    model_reset();
    #2;
    chk("rst_ack", 32'(o_ack), 32'(0));
    chk("rst_cmd", 32'({o_owt_tx_wr_cmd_vld, o_owt_tx_rd_cmd_vld}), 32'(0));
    run(2);
    i_rst_n = 1'b1; in_rst = 1'b0; next_idle = cyc;
    i_tx_en = 1'b1;
    run(3);

    // single write request from requester 1
    i_req_addr[1*AW +: AW] = 7'h15; i_req_data[1*DW +: DW] = 10'h2A5;
    i_req_wr = 3'b010; i_req = 3'b010;
    eng_d = 2; eng_L = 60; eng_to = 1'b0;
    cycle_end();
    chk("single_ack", 32'(o_ack), 32'(3'b010));
    chk("single_wr", 32'(o_owt_tx_wr_cmd_vld), 32'(1));
    i_req = '0;
    cnt = 0;
    while (o_done == '0 && cnt < 200) begin cycle_end(); cnt++; end
    chk("single_done_lat", 32'(cnt), 32'(63));
    chk("single_done", 32'(o_done), 32'(3'b010));
    chk("single_addr", 32'(o_owt_tx_addr), 32'(7'h15));
    run(30);

    // start timeout on a read from requester 0
    i_req_addr[0 +: AW] = 7'h3C; i_req_data[0 +: DW] = 10'h155;
    i_req_wr = 3'b000; i_req = 3'b001; eng_to = 1'b1;
    cycle_end();
    chk("to_rd", 32'(o_owt_tx_rd_cmd_vld), 32'(1));
    cnt = 0;
    while (!o_tx_err && cnt < 100) begin cycle_end(); cnt++; end
    chk("to_err_lat", 32'(cnt), 32'(STO + 1));
    chk("to_done", 32'(o_done), 32'(3'b001));
    eng_to = 1'b0; eng_d = 2; eng_L = 5;
    cnt = 0;
    while (!(o_owt_tx_wr_cmd_vld || o_owt_tx_rd_cmd_vld) && cnt < 100) begin cycle_end(); cnt++; end
    chk("to_next_cmd", 32'(cnt), 32'(GAP + 1));
    i_req = '0;
    run(40);

    // enable gating
    i_tx_en = 1'b0; i_req = 3'b001; i_req_wr = 3'b001;
    run(100);
    i_tx_en = 1'b1; eng_d = 2; eng_L = 20;
    cycle_end();
    chk("en_ack", 32'(o_ack), 32'(3'b001));
    i_req = '0;
    run(5);
    i_tx_en = 1'b0;
    cnt = 0;
    while (o_done == '0 && cnt < 100) begin cycle_end(); cnt++; end
    chk("en_done", 32'(o_done), 32'(3'b001));
    i_tx_en = 1'b1;
    run(30);

    // reset in the middle of a frame
    i_req = 3'b010; i_req_wr = 3'b010; eng_d = 2; eng_L = 50;
    cycle_end();
    i_req = '0;
    run(10);
    i_rst_n = 1'b0;
    #1;
    chk("mrst_ack", 32'(o_ack), 32'(0));
    chk("mrst_done", 32'(o_done), 32'(0));
    chk("mrst_err", 32'(o_tx_err), 32'(0));
    chk("mrst_cmd", 32'({o_owt_tx_wr_cmd_vld, o_owt_tx_rd_cmd_vld}), 32'(0));
    chk("mrst_addr", 32'(o_owt_tx_addr), 32'(0));
    chk("mrst_data", 32'(o_owt_tx_data), 32'(0));
    model_reset();
    run(3);
    i_rst_n = 1'b1; in_rst = 1'b0; next_idle = cyc;
    run(30);

    // contention with back-to-back spacing
    i_req_addr = 21'h1A2B3C; i_req_data = 30'h2345_6789; i_req_wr = 3'b101;
    eng_d = 2; eng_L = 5;
    ack_log.delete(); meas_gap = 1'b1; last_done_obs = -1;
    i_req = 3'b111;
    cnt = 0;
    while (ack_log.size() < 4 && cnt < 400) begin cycle_end(); cnt++; end
    i_req = '0;
    chk("cont_count", 32'(ack_log.size()), 32'(4));
`ifdef HV_OWT_TX_SCHED_RR_EN
    chk("cont_grant0", 32'(ack_log[0]), 32'(3'b001));
    chk("cont_grant1", 32'(ack_log[1]), 32'(3'b010));
    chk("cont_grant2", 32'(ack_log[2]), 32'(3'b100));
    chk("cont_grant3", 32'(ack_log[3]), 32'(3'b001));
`else
    chk("cont_grant0", 32'(ack_log[0]), 32'(3'b001));
    chk("cont_grant1", 32'(ack_log[1]), 32'(3'b001));
    chk("cont_grant2", 32'(ack_log[2]), 32'(3'b001));
    chk("cont_grant3", 32'(ack_log[3]), 32'(3'b001));
`endif
    run(40);
    meas_gap = 1'b0;

    // random traffic
    eng_rand = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (cyc == fI && fg == k) begin
          rq_on[k] = ($urandom_range(0, 1) == 1);
          if (rq_on[k]) begin
            i_req_wr[k] = 1'($urandom_range(0, 1));
            i_req_addr[k*AW +: AW] = AW'($urandom);
            i_req_data[k*DW +: DW] = DW'($urandom);
          end
        end else if (rq_on[k]) begin
          if ($urandom_range(0, 63) == 0) rq_on[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rq_on[k] = 1'b1;
          i_req_wr[k] = 1'($urandom_range(0, 1));
          i_req_addr[k*AW +: AW] = AW'($urandom);
          i_req_data[k*DW +: DW] = DW'($urandom);
        end
        i_req[k] = rq_on[k];
      end
      if ($urandom_range(0, 49) == 0) i_tx_en = ~i_tx_en;
      cycle_end();
    end
    i_req = '0; i_tx_en = 1'b1;
    run(120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
